// File: rtl/search_fifo.sv
// Circular-buffer FIFO with valid/ready on both sides, occupancy count, almost-full,
// synchronous flush and a combinational key lookup over resident entries.
// Latency: push visible on out_data/lookup next cycle; no bypass. Backpressure: in_ready = !full.
module search_fifo #(
    parameter int DATA_W       = 64,
    parameter int KEY_W        = 32,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    input  logic                       flush,
    input  logic [KEY_W-1:0]           lookup_key,
    output logic                       lookup_hit,
    output logic [DATA_W-1:0]          lookup_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic empty;
    logic full;
    logic push_fire;
    logic pop_fire;

    assign empty       = (head_q == tail_q);
    assign full        = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                         (head_q[IDX_W] != tail_q[IDX_W]);
    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign out_data    = mem_q[head_q[IDX_W-1:0]];
    assign count       = tail_q - head_q;
    assign almost_full = (count >= PTR_W'(AFULL_THRESH));

    // Flush wins over both handshakes: nothing is stored or consumed that cycle.
    assign push_fire   = in_valid && !full && !flush;
    assign pop_fire    = out_valid && out_ready && !flush;

    // Next-state pointers: flush clears both, otherwise advance on each fired handshake.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (pop_fire)  head_d = head_q + PTR_W'(1);
            if (push_fire) tail_d = tail_q + PTR_W'(1);
        end
    end

    // Pointer and storage registers; storage is cleared on reset so outputs are never X.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (push_fire) begin
                mem_q[tail_q[IDX_W-1:0]] <= in_data;
            end
        end
    end

    // Lookup walks from head in FIFO order so the oldest matching entry wins.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx         = '0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q[IDX_W-1:0] + IDX_W'(k);
            if (!lookup_hit && (PTR_W'(k) < count) &&
                (mem_q[idx][KEY_W-1:0] == lookup_key)) begin
                lookup_hit  = 1'b1;
                lookup_data = mem_q[idx];
            end
        end
    end

    // Structural sanity checks on the pointer state.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(full && empty));
            assert (count <= PTR_W'(DEPTH));
            assert (!$isunknown({in_ready, out_valid, out_data, lookup_hit,
                                 lookup_data, count, almost_full}));
        end
    end

endmodule

// File: tb/tb_search_fifo.sv
// Directed self-checking bench for search_fifo (DEPTH=8, DATA_W=64, KEY_W=32).
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
// Each comparison is an immediate assertion that counts and reports failures.
module tb_search_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic        flush;
    logic [31:0] lookup_key;
    logic        lookup_hit;
    logic [63:0] lookup_data;
    logic [3:0]  count;
    logic        almost_full;

    int tests  = 0;
    int failed = 0;

    search_fifo #(.DATA_W(64), .KEY_W(32), .DEPTH(8), .AFULL_THRESH(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flush       (flush),
        .lookup_key  (lookup_key),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    localparam logic [63:0] E0 = 64'h1111_0000_0000_000A;
    localparam logic [63:0] E1 = 64'h2222_0000_0000_000B;
    localparam logic [63:0] E2 = 64'h3333_0000_0000_000A;

    initial begin
        logic [63:0] head_val;
        logic [63:0] next_in;
        int          mcount;
        logic        do_push;
        logic        do_pop;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; lookup_key = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // 1: reset / idle state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_hit", lookup_hit, 0);
        chk("rst_ldata", lookup_data, 0);

        // 2: fill to full, almost_full from 6, 9th push held, drain in order
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h100 + 64'(i);
            chk("t2_rdy_before", in_ready, 1);
            tick();
            chk("t2_count", count, 64'(i + 1));
            chk("t2_afull", almost_full, (i + 1) >= 6);
        end
        chk("t2_full_rdy", in_ready, 0);
        in_data = 64'h108;
        tick();
        chk("t2_held_count", count, 8);
        chk("t2_held_rdy", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_pop_vld", out_valid, 1);
            chk("t2_pop_dat", out_data, 64'h100 + 64'(i));
            tick();
        end
        chk("t2_empty_vld", out_valid, 0);
        chk("t2_empty_cnt", count, 0);
        tick();
        chk("t2_no_underflow", count, 0);
        out_ready = 1'b0;

        // 3: full FIFO with continuous push and pop; pointers wrap repeatedly
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h200 + 64'(i);
            tick();
        end
        in_valid = 1'b0;
        head_val = 64'h200;
        next_in  = 64'h208;
        mcount   = 8;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            in_data = next_in;
            chk("t3_count", count, 64'(mcount));
            chk("t3_head", out_data, head_val);
            chk("t3_rdy", in_ready, mcount < 8);
            tick();
            do_push = (mcount < 8);
            do_pop  = (mcount > 0);
            if (do_pop)  begin head_val = head_val + 1; mcount = mcount - 1; end
            if (do_push) begin next_in  = next_in + 1;  mcount = mcount + 1; end
        end
        in_valid = 1'b0;
        while (mcount > 0) begin
            chk("t3_drain", out_data, head_val);
            tick();
            head_val = head_val + 1;
            mcount   = mcount - 1;
        end
        chk("t3_drained_cnt", count, 0);
        chk("t3_all_pushed", next_in, 64'h208 + 64'd39);
        out_ready = 1'b0;

        // 4: simultaneous push+pop at count 3, then on an empty queue
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h300 + 64'(i);
            tick();
        end
        chk("t4_cnt3", count, 3);
        in_data   = 64'h303;
        out_ready = 1'b1;
        tick();
        chk("t4_pp_cnt", count, 3);
        chk("t4_pp_head", out_data, 64'h301);
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk("t4_pp_order", out_data, 64'h300 + 64'(i));
            tick();
        end
        chk("t4_empty", out_valid, 0);
        in_valid = 1'b1;
        in_data  = 64'h400;
        tick();
        chk("t4_empty_pp_cnt", count, 1);
        chk("t4_empty_pp_dat", out_data, 64'h400);
        in_valid = 1'b0;
        tick();
        chk("t4_final_cnt", count, 0);
        out_ready = 1'b0;

        // 5: associative lookup, oldest match wins
        in_valid = 1'b1;
        in_data = E0; tick();
        in_data = E1; tick();
        in_data = E2;
        lookup_key = 32'hA;
        #1;
        chk("t5_excl_push_dat", lookup_data, E0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t5_hit_a", lookup_hit, 1);
        chk("t5_data_a", lookup_data, E0);
        lookup_key = 32'hB; #1;
        chk("t5_data_b", lookup_data, E1);
        lookup_key = 32'hA;
        out_ready  = 1'b1; #1;
        chk("t5_incl_pop", lookup_data, E0);
        tick();
        out_ready = 1'b0;
        #1;
        chk("t5_after_pop", lookup_data, E2);
        lookup_key = 32'hC; #1;
        chk("t5_miss_hit", lookup_hit, 0);
        chk("t5_miss_dat", lookup_data, 0);

        // 6: flush at count 5 with push and pop requested
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 64'h500 + 64'(i);
            tick();
        end
        chk("t6_cnt5", count, 5);
        in_data    = 64'h5FF;
        out_ready  = 1'b1;
        flush      = 1'b1;
        lookup_key = 32'hA; #1;
        chk("t6_lookup_during_flush", lookup_data, E2);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("t6_cnt", count, 0);
        chk("t6_vld", out_valid, 0);
        chk("t6_rdy", in_ready, 1);
        chk("t6_miss_a", lookup_hit, 0);
        lookup_key = 32'h5FF; #1;
        chk("t6_miss_pushed", lookup_hit, 0);
        in_valid = 1'b1; in_data = 64'h600;
        tick();
        in_valid = 1'b0;
        chk("t6_post_flush_dat", out_data, 64'h600);
        chk("t6_post_flush_cnt", count, 1);

        // Reset mid-operation overrides a pending push
        in_valid = 1'b1; in_data = 64'h700;
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_mid_cnt", count, 0);
        chk("rst_mid_vld", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
